note_draw_scheduler: RTL

//  Upstream of the shape-drawing FSM in the display path. Holds a table of falling notes.
//  On each frame tick it walks the table and issues one draw request per shape to the drawer:
//  an erase at the old position, then a draw at the new position.

---
 rtl/display_pkg.sv | 28 ++
 rtl/note_slot_table.sv | 78 +++++++
 rtl/note_draw_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared display-path types and constants for the note draw scheduler.
package display_pkg;

  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;

  localparam logic [2:0] COLOUR_BG = 3'b000;
  // Indexed by lane: lane 0 = 3'b100 ... lane 3 = 3'b110.
  localparam logic [3:0][2:0] LANE_COLOUR = {3'b110, 3'b001, 3'b010, 3'b100};

  typedef struct packed {
    logic           valid;
    logic           drawn;
    logic [1:0]     lane;
    logic [Y_W-1:0] y;
  } note_slot_t;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StReq,
    StWaitLo,
    StWaitHi,
    StUpdate,
    StNext
  } sched_state_e;

endpackage

// File: rtl/note_slot_table.sv
// Falling-note slot storage: spawn into the lowest free slot, one scheduler write port,
// free-slot flag and registered valid count.
module note_slot_table
  import display_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned Y_START   = 0,
  localparam int unsigned IdxW     = $clog2(NUM_SLOTS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            spawn_valid_i,
  input  logic [1:0]      spawn_lane_i,
  output logic            spawn_ready_o,
  output logic [3:0]      active_count_o,
  input  logic [IdxW-1:0] rd_idx_i,
  output logic            rd_valid_o,
  output logic            rd_drawn_o,
  output logic [1:0]      rd_lane_o,
  output logic [Y_W-1:0]  rd_y_o,
  input  logic            wr_en_i,
  input  logic            wr_valid_i,
  input  logic            wr_drawn_i,
  input  logic [Y_W-1:0]  wr_y_i
);

  note_slot_t            slots_q [NUM_SLOTS];
  logic                  free_found;
  logic [IdxW-1:0]       free_idx;
  logic [3:0]            count_d;
  logic [3:0]            count_q;

  // Descending scan so the last hit is the lowest-index free slot.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    count_d    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slots_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
      count_d = count_d + {3'b000, slots_q[i].valid};
    end
  end

  // The scheduler only writes valid slots and spawn only targets invalid ones,
  // so the two write ports never collide.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      if (wr_en_i) begin
        slots_q[rd_idx_i].valid <= wr_valid_i;
        slots_q[rd_idx_i].drawn <= wr_drawn_i;
        slots_q[rd_idx_i].y     <= wr_y_i;
      end
      if (spawn_valid_i && free_found) begin
        slots_q[free_idx].valid <= 1'b1;
        slots_q[free_idx].drawn <= 1'b0;
        slots_q[free_idx].lane  <= spawn_lane_i;
        slots_q[free_idx].y     <= Y_W'(Y_START);
      end
      count_q <= count_d;
    end
  end

  assign spawn_ready_o  = free_found;
  assign active_count_o = count_q;
  assign rd_valid_o     = slots_q[rd_idx_i].valid;
  assign rd_drawn_o     = slots_q[rd_idx_i].drawn;
  assign rd_lane_o      = slots_q[rd_idx_i].lane;
  assign rd_y_o         = slots_q[rd_idx_i].y;

endmodule

// File: rtl/note_draw_scheduler.sv
// Per-frame walk of the note table issuing draw requests to the shape drawer.
// Define NOTE_ERASE_EN to erase each drawn note at its old position before moving it.
module note_draw_scheduler
  import display_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 8,
  parameter int unsigned LANE_X0    = 16,
  parameter int unsigned LANE_PITCH = 32,
  parameter int unsigned Y_START    = 0,
  parameter int unsigned SPEED      = 2,
  parameter int unsigned Y_LIMIT    = 112
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           frameTick,
  input  logic           spawnValid,
  input  logic [1:0]     spawnLane,
  output logic           spawnReady,
  output logic           startingAddressLoaded,
  output logic [X_W-1:0] xStart,
  output logic [Y_W-1:0] yStart,
  output logic [2:0]     colour,
  input  logic           shapeDone,
  output logic           frameBusy,
  output logic           frameOverrun,
  output logic [3:0]     activeCount
);

  localparam int unsigned IdxW = $clog2(NUM_SLOTS);

  sched_state_e    state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            pending_q, pending_d;
  logic            erase_q, erase_d;
  logic [X_W-1:0]  x_q;
  logic [Y_W-1:0]  y_q;
  logic [2:0]      colour_q;

  logic            load_req;
  logic [X_W-1:0]  req_x;
  logic [Y_W-1:0]  req_y;
  logic [2:0]      req_colour;
  logic [X_W-1:0]  y_next;
  logic            overrun;

  logic            table_ready;
  logic            rd_valid, rd_drawn;
  logic [1:0]      rd_lane;
  logic [Y_W-1:0]  rd_y;
  logic            wr_en, wr_valid, wr_drawn;
  logic [Y_W-1:0]  wr_y;

  note_slot_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .Y_START   (Y_START)
  ) u_table (
    .clock          (clock),
    .reset          (reset),
    .spawn_valid_i  (spawnValid),
    .spawn_lane_i   (spawnLane),
    .spawn_ready_o  (table_ready),
    .active_count_o (activeCount),
    .rd_idx_i       (idx_q),
    .rd_valid_o     (rd_valid),
    .rd_drawn_o     (rd_drawn),
    .rd_lane_o      (rd_lane),
    .rd_y_o         (rd_y),
    .wr_en_i        (wr_en),
    .wr_valid_i     (wr_valid),
    .wr_drawn_i     (wr_drawn),
    .wr_y_i         (wr_y)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    erase_d    = erase_q;
    load_req   = 1'b0;
    req_x      = X_W'(LANE_X0) + X_W'(LANE_PITCH) * X_W'(rd_lane);
    req_y      = rd_y;
    req_colour = LANE_COLOUR[rd_lane];
    y_next     = {1'b0, rd_y} + X_W'(SPEED);
    overrun    = 1'b0;
    wr_en      = 1'b0;
    wr_valid   = rd_valid;
    wr_drawn   = rd_drawn;
    wr_y       = rd_y;

    // One tick may queue behind a running walk; any more are dropped.
    if (frameTick && state_q != StIdle) begin
      if (pending_q) begin
        overrun = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (frameTick || pending_q) begin
          state_d   = StScan;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      StScan: begin
        if (!rd_valid) begin
          state_d = StNext;
        end else if (!rd_drawn) begin
          load_req = 1'b1;
          erase_d  = 1'b0;
          req_y    = Y_W'(Y_START);
          state_d  = StReq;
        end else begin
`ifdef NOTE_ERASE_EN
          load_req   = 1'b1;
          erase_d    = 1'b1;
          req_colour = COLOUR_BG;
          state_d    = StReq;
`else
          state_d = StUpdate;
`endif
        end
      end
      StReq: state_d = StWaitLo;
      // Drawer is idle-high, so completion needs a low phase first.
      StWaitLo: begin
        if (!shapeDone) state_d = StWaitHi;
      end
      StWaitHi: begin
        if (shapeDone) begin
          if (erase_q) begin
            state_d = StUpdate;
          end else begin
            wr_en    = 1'b1;
            wr_drawn = 1'b1;
            state_d  = StNext;
          end
        end
      end
      StUpdate: begin
        wr_en = 1'b1;
        if (y_next > X_W'(Y_LIMIT)) begin
          wr_valid = 1'b0;
          state_d  = StNext;
        end else begin
          wr_y     = y_next[Y_W-1:0];
          load_req = 1'b1;
          erase_d  = 1'b0;
          req_y    = y_next[Y_W-1:0];
          state_d  = StReq;
        end
      end
      StNext: begin
        if (idx_q == IdxW'(NUM_SLOTS - 1)) begin
          state_d = StIdle;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StScan;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pending_q <= 1'b0;
      erase_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      erase_q   <= erase_d;
      if (load_req) begin
        x_q      <= req_x;
        y_q      <= req_y;
        colour_q <= req_colour;
      end
    end
  end

  // Gated by reset so nothing leaks out during the reset cycle.
  assign startingAddressLoaded = (state_q == StReq) && !reset;
  assign frameBusy             = (state_q != StIdle) && !reset;
  assign frameOverrun          = overrun && !reset;
  assign spawnReady            = table_ready && !reset;
  assign xStart                = x_q;
  assign yStart                = y_q;
  assign colour                = colour_q;

endmodule
